// File: rtl/mul_hilo_capture_if.sv
// rtl/mul_hilo_capture_if.sv - operand, multiplier and HI/LO signal bundle for mul_hilo_capture
interface mul_hilo_capture_if;
  logic        start;
  logic [31:0] x_in;
  logic [31:0] y_in;
  logic [31:0] mul_x;
  logic [31:0] mul_y;
  logic [63:0] mul_product;
  logic        hi_load;
  logic [31:0] hi_in;
  logic        lo_load;
  logic [31:0] lo_in;
  logic        busy;
  logic        done;
  logic [31:0] hi_out;
  logic [31:0] lo_out;
  logic        ovf;

  modport master (
    output start, x_in, y_in, mul_product, hi_load, hi_in, lo_load, lo_in,
    input  mul_x, mul_y, busy, done, hi_out, lo_out, ovf
  );

  modport slave (
    input  start, x_in, y_in, mul_product, hi_load, hi_in, lo_load, lo_in,
    output mul_x, mul_y, busy, done, hi_out, lo_out, ovf
  );
endinterface

// File: rtl/mul_hilo_capture.sv
// rtl/mul_hilo_capture.sv - multicycle sequencer and HI/LO writeback for a combinational multiplier
// Operands are held stable for SETTLE_CYCLES edges before the product is captured.
module mul_hilo_capture #(
  parameter int SETTLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic              clk,
  input  logic              reset,
  mul_hilo_capture_if.slave bus
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_SETTLE = 1'b1;

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  logic [0:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      mul_x_q;
  logic [31:0]      mul_y_q;
  logic [31:0]      hi_q;
  logic [31:0]      lo_q;
  logic             done_q;
  logic             ovf_q;
  logic             prod_ovf;

  // Product fits in 32 bits only when the high word is the sign extension of the low word.
  assign prod_ovf = (bus.mul_product[63:32] != {32{bus.mul_product[31]}});

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      mul_x_q <= '0;
      mul_y_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            mul_x_q <= bus.x_in;
            mul_y_q <= bus.y_in;
            cnt     <= CNT_LOAD;
            state   <= ST_SETTLE;
          end
          if (bus.hi_load) hi_q <= bus.hi_in;
          if (bus.lo_load) lo_q <= bus.lo_in;
        end
        ST_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            hi_q   <= bus.mul_product[63:32];
            lo_q   <= bus.mul_product[31:0];
            ovf_q  <= prod_ovf;
            done_q <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mul_x  = mul_x_q;
  assign bus.mul_y  = mul_y_q;
  assign bus.busy   = (state == ST_SETTLE);
  assign bus.done   = done_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;
  assign bus.ovf    = ovf_q;

endmodule

// File: doc/mul_hilo_capture.md
Name: mul_hilo_capture

Overview:
Sequencing and writeback stage that sits directly downstream of the combinational 32x32 signed Booth multiplier. It latches operands on a start request and drives them to the multiplier. It waits a programmable number of cycles so the multiplier's deep combinational path settles as a multicycle path. It then captures the 64-bit product into the HI/LO register pair that the datapath reads. It also supports direct HI/LO loads (MTHI/MTLO-style) and flags products that do not fit in 32 bits.

Parameters:
SETTLE_CYCLES, 4, clock edges from the operand latch to product capture; legal range is 1..255.
CNT_W, 8, width of the settle counter; must hold SETTLE_CYCLES-1.

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
start  in  1  request a multiply; sampled only in IDLE
x_in  in  32  multiplicand, latched when start is accepted
y_in  in  32  multiplier, latched when start is accepted
mul_x  out  32  registered operand driven to the multiplier x input
mul_y  out  32  registered operand driven to the multiplier y input
mul_product  in  64  signed product returned from the multiplier
hi_load  in  1  load HI from hi_in; honoured only in IDLE
hi_in  in  32  direct HI load data
lo_load  in  1  load LO from lo_in; honoured only in IDLE
lo_in  in  32  direct LO load data
busy  out  1  high while in SETTLE
done  out  1  registered one-cycle pulse; HI/LO hold the new product in the same cycle
hi_out  out  32  HI register (product[63:32])
lo_out  out  32  LO register (product[31:0])
ovf  out  1  captured product is not the sign extension of its low word

Behaviour:
- Reset (sync, active-high), on any edge with reset=1 and regardless of state:
  - state <= IDLE.
  - mul_x, mul_y, hi_out, lo_out, counter <= 0.
  - done, ovf <= 0.
  - reset mid-SETTLE aborts the operation: no capture, no done pulse.
- FSM states: IDLE and SETTLE. busy = (state == SETTLE), decoded combinationally from the state register.
- IDLE, on an edge with start=1:
  - mul_x <= x_in, mul_y <= y_in.
  - counter <= SETTLE_CYCLES-1.
  - state <= SETTLE.
  - With start=0, all registers hold.
- SETTLE, on an edge with counter != 0: counter decrements; mul_x/mul_y hold; start, hi_load and lo_load are ignored.
- SETTLE, on an edge with counter == 0:
  - hi_out <= mul_product[63:32], lo_out <= mul_product[31:0].
  - ovf <= (mul_product[63:32] != {32{mul_product[31]}}).
  - done <= 1, state <= IDLE.
- Latency: start sampled at edge E0 -> capture and done rise at edge E(SETTLE_CYCLES). done is high for exactly one cycle and never overlaps busy.
- done defaults to 0 on every other edge. Back-to-back operation: start may be asserted in the done cycle and is accepted, because the FSM is already in IDLE.
- Direct loads, IDLE only:
  - hi_load=1 -> hi_out <= hi_in; lo_load=1 -> lo_out <= lo_in.
  - Both may be asserted in the same cycle.
  - A load and start in the same IDLE cycle are both performed.
  - Loads do not modify ovf.
- Capture edge vs. load: loads are ignored in SETTLE, so the capture always wins.
- Operand stability: mul_x/mul_y change only on start acceptance or reset. x_in/y_in may change freely while busy.
- Arithmetic: mul_product is two's complement. ovf is computed on the signed interpretation. The block performs no arithmetic of its own.

Test Plan:
1. Assert reset for 2 cycles with nonzero inputs -> hi_out=lo_out=mul_x=mul_y=0, done=busy=ovf=0.
2. SETTLE_CYCLES=4, start with x_in=7, y_in=0xFFFFFFFD (-3) at edge E0 -> busy high between E0 and E4. At E4: hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB, ovf=0, done high for exactly one cycle.
3. x_in=0x80000000, y_in=0x80000000 -> hi_out=0x40000000, lo_out=0x00000000, ovf=1. Then 5*6 -> hi_out=0, lo_out=30, ovf=0.
4. Start 3*4, then pulse start with 9*9 and hi_load=1 (hi_in=0xDEAD0000) mid-SETTLE -> both ignored; the result is hi_out=0, lo_out=12. Start in the done cycle with 2*2 -> accepted; lo_out=4 after 4 more edges.
5. In IDLE, hi_load=1 with hi_in=0x12345678 and lo_load=1 with lo_in=0x9ABCDEF0 -> both registers take those values next edge and ovf is unchanged. Repeat with start=1 in the same cycle -> the loads occur now and the product overwrites them at capture.
6. Start 100*100, then assert reset at the second SETTLE edge -> IDLE, all outputs 0, no done pulse. The next start with 100*100 -> lo_out=10000 after SETTLE_CYCLES edges.
